// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Write side of program memory. A host byte link delivers a load frame, and
// this block turns it into 13-bit instruction writes on the PM write port.
// While a load is in progress, or after one has failed, the core is held.
//
// Frame: COUNT (N = 1..DEPTH), then N x {HI, LO}, then an optional CHK byte.
// Each instruction is {HI[4:0], LO}. HI[7:5] are reserved and must be zero.
//
// Optional feature, enabled by defining the macro PL_CHECKSUM_EN:
//   When defined, a trailing CHK byte is required. It must equal the XOR of
//   the COUNT byte and every HI and LO byte.
//   When undefined, the load finishes right after the last PM write.
//
// Handshake: a byte moves on the cycle when in_valid && in_ready are both
//   high at the rising clock edge. in_ready depends only on the state, never
//   on in_valid. While in_ready is low, the source must hold its byte.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   start      in   1-cycle pulse: begin a new load (ignored mid-frame)
//   in_valid   in   byte available on in_data
//   in_data    in   8-bit stream byte
//   in_ready   out  loader accepts a byte this cycle
//   pm_we      out  PM write enable, one cycle per instruction
//   pm_addr    out  PM write address
//   pm_wdata   out  PM write data
//   cpu_hold   out  hold core/PC while loading or after an error
//   done       out  load finished OK (level until next start/reset)
//   err        out  load failed (sticky until next start/reset)
//   state_dbg  out  current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int INS_WIDTH  = 13,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [INS_WIDTH-1:0]  pm_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  localparam int HI_W = INS_WIDTH - 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]            state;
  // One bit wider than the address, so that N == DEPTH can be represented.
  logic [ADDR_WIDTH:0]   count_n;
  logic [ADDR_WIDTH:0]   counter;
  logic [ADDR_WIDTH:0]   counter_inc;
  logic [HI_W-1:0]       hi_q;
  logic                  xfer;
  logic                  count_bad;
  logic                  hi_reserved;
`ifdef PL_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  assign xfer        = in_valid & in_ready;
  assign counter_inc = counter + 1'b1;
  assign count_bad   = (in_data == 8'd0) || (32'(in_data) > DEPTH);
  assign hi_reserved = (in_data[7:HI_W] != '0);

  // All outputs are decoded from the registered state, so they are glitch-free.
  always_comb begin
    in_ready = (state == S_COUNT) || (state == S_HI) ||
               (state == S_LO)    || (state == S_CHECK);
  end

  assign pm_we     = (state == S_WRITE);
  assign cpu_hold  = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERROR);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count_n  <= '0;
      counter  <= '0;
      hi_q     <= '0;
      pm_addr  <= '0;
      pm_wdata <= '0;
`ifdef PL_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state   <= S_COUNT;
            counter <= '0;
            pm_addr <= '0;
`ifdef PL_CHECKSUM_EN
            chk     <= '0;
`endif
          end
        end
        S_COUNT: begin
          if (xfer) begin
            count_n <= in_data[ADDR_WIDTH:0];
`ifdef PL_CHECKSUM_EN
            chk     <= chk ^ in_data;
`endif
            state   <= count_bad ? S_ERROR : S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
`ifdef PL_CHECKSUM_EN
            chk <= chk ^ in_data;
`endif
            if (hi_reserved) begin
              state <= S_ERROR;
            end else begin
              hi_q  <= in_data[HI_W-1:0];
              state <= S_LO;
            end
          end
        end
        S_LO: begin
          if (xfer) begin
`ifdef PL_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
            pm_wdata <= {hi_q, in_data};
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          counter <= counter_inc;
          if (counter_inc == count_n) begin
            // The address is held on the last write. This way, a full
            // DEPTH-entry load never wraps pm_addr back to zero.
`ifdef PL_CHECKSUM_EN
            state <= S_CHECK;
`else
            state <= S_DONE;
`endif
          end else begin
            pm_addr <= pm_addr + 1'b1;
            state   <= S_HI;
          end
        end
`ifdef PL_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            state <= (in_data == chk) ? S_DONE : S_ERROR;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Inputs are driven 1 ns after the rising
// edge. Outputs are checked at that same point. A negedge monitor captures
// every PM write into got_q. Each directed step compares got_q with exp_q,
// which the bench builds from its own hand-computed values.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam int W = 19;  // {addr[5:0], data[12:0]}

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pm_we;
  logic [5:0]  pm_addr;
  logic [12:0] pm_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         ready_during_we;
  logic [7:0]   sum;
  int           total;
  int           bad;

  program_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .pm_wdata (pm_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PM write monitor
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      got_q.push_back({pm_addr, pm_wdata});
      if (in_ready !== 1'b0) ready_during_we = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("byte_accept_timeout", (n >= 40) ? 32'd1 : 32'd0, 32'd0);
    tick();
    sum      = sum ^ b;
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  // Leave in_valid low for one cycle, with junk on in_data, then send the byte.
  task automatic send_byte_gap(input logic [7:0] b);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    tick();
    send_byte(b);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("end_timeout", (n >= 60) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic begin_load();
    got_q.delete();
    exp_q.delete();
    ready_during_we = 1'b0;
    sum = 8'h00;
    pulse_start();
  endtask

  initial begin
    logic [12:0] d;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    sum = 8'h00;
    ready_during_we = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_pm_we", pm_we, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pm_addr", pm_addr, 0);
    check("rst_pm_wdata", pm_wdata, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    // Good load: 02, 1A,05, 01,23 [, 3F]
    begin_load();
    check("good_hold_after_start", cpu_hold, 1);
    check("good_ready_in_count", in_ready, 1);
    exp_q.push_back({6'd0, 13'h1A05});
    exp_q.push_back({6'd1, 13'h0123});
    send_byte(8'h02);
    send_byte(8'h1A);
    send_byte(8'h05);
    check("good_we_after_lo", pm_we, 1);
    check("good_ready_in_write", in_ready, 0);
    check("good_addr0", pm_addr, 0);
    send_byte(8'h01);
    send_byte(8'h23);
`ifdef PL_CHECKSUM_EN
    check("good_sum", sum, 8'h3F);
    send_byte(8'h3F);
`endif
    wait_end();
    check_writes("good");
    check("good_done", done, 1);
    check("good_err", err, 0);
    check("good_hold", cpu_hold, 0);
    check("good_ready_done", in_ready, 0);
    check("good_no_ready_in_we", ready_during_we, 0);

`ifdef PL_CHECKSUM_EN
    // Bad checksum: both writes still happen
    begin_load();
    exp_q.push_back({6'd0, 13'h1A05});
    exp_q.push_back({6'd1, 13'h0123});
    send_byte(8'h02);
    send_byte(8'h1A);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h3E);
    wait_end();
    check_writes("badchk");
    check("badchk_err", err, 1);
    check("badchk_done", done, 0);
    check("badchk_hold", cpu_hold, 1);
`endif

    // Illegal count 0
    begin_load();
    send_byte(8'h00);
    check("n0_err", err, 1);
    check("n0_hold", cpu_hold, 1);
    check("n0_done", done, 0);
    repeat (3) tick();
    check_writes("n0");

    // Illegal count 65
    begin_load();
    send_byte(8'h41);
    check("n65_err", err, 1);
    repeat (3) tick();
    check_writes("n65");

    // Reserved HI bits
    begin_load();
    send_byte(8'h01);
    send_byte(8'h3A);
    check("rsv_err", err, 1);
    check("rsv_ready", in_ready, 0);
    check("rsv_state", state_dbg, 7);
    repeat (3) tick();
    check_writes("rsv");

    // Backpressure plus a mid-frame start: PM contents must not change
    begin_load();
    exp_q.push_back({6'd0, 13'h1A05});
    exp_q.push_back({6'd1, 13'h0123});
    send_byte_gap(8'h02);
    send_byte_gap(8'h1A);
    pulse_start();
    send_byte_gap(8'h05);
    send_byte_gap(8'h01);
    start = 1'b1;
    send_byte_gap(8'h23);
    start = 1'b0;
`ifdef PL_CHECKSUM_EN
    send_byte_gap(8'h3F);
`endif
    wait_end();
    check_writes("bp");
    check("bp_done", done, 1);
    check("bp_no_ready_in_we", ready_during_we, 0);

    // Reset during the first WRITE
    begin_load();
    exp_q.push_back({6'd0, 13'h1A05});
    send_byte(8'h02);
    send_byte(8'h1A);
    send_byte(8'h05);
    check("mid_we", pm_we, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_we", pm_we, 0);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_addr", pm_addr, 0);
    check("mid_rst_wdata", pm_wdata, 0);
    check("mid_rst_state", state_dbg, 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h01;
    repeat (4) tick();
    in_valid = 1'b0;
    check("mid_idle_state", state_dbg, 0);
    check_writes("mid");

    // Full 64-instruction load
    begin_load();
    send_byte(8'h40);
    for (int i = 0; i < 64; i++) begin
      d = 13'((i * 613 + 77) % 8192);
      exp_q.push_back({6'(i), d});
      send_byte({3'b000, d[12:8]});
      send_byte(d[7:0]);
    end
`ifdef PL_CHECKSUM_EN
    send_byte(sum);
`endif
    wait_end();
    check_writes("full");
    check("full_done", done, 1);
    check("full_err", err, 0);
    check("full_hold", cpu_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
